// File: rtl/mac_seq.sv
// mac_seq: sequences one dot-product job through an external accumulate-only MAC.
// Clears the accumulator, streams len operand pairs, waits out the MAC latency,
// then holds the 16-bit result and a sticky wrap flag until the consumer takes it.
module mac_seq #(
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             aclrn,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic [7:0]       a_data,
  input  logic [7:0]       b_data,
  input  logic             op_valid,
  output logic             op_ready,
  output logic [7:0]       mac_ina,
  output logic [7:0]       mac_inb,
  output logic             mac_sclrn,
  input  logic [15:0]      mac_out,
  output logic [15:0]      res_data,
  output logic             res_ovf,
  output logic             res_valid,
  input  logic             res_ready
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    RUN    = 3'd2,
    DRAIN  = 3'd3,
    RESULT = 3'd4
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [LEN_W-1:0] cnt_q;
  logic [15:0]      prev_q;
  logic             beat_q;
  logic             ovf_q;
  logic [15:0]      res_data_q;
  logic             res_ovf_q;
  logic             beat_c;
  logic             wrap_c;

  // A beat transfers only while RUN advertises ready
  assign beat_c = (state_q == RUN) && op_valid;

  // Accumulator dropped below its previous value after a beat: exactly one wrap
  assign wrap_c = beat_q && (mac_out < prev_q);

  // Handshake and MAC control are decodes of the state register
  assign busy      = (state_q != IDLE);
  assign op_ready  = (state_q == RUN);
  assign res_valid = (state_q == RESULT);
  assign mac_sclrn = (state_q != CLEAR);

  // Operands reach the MAC only on a firing beat so it adds 0 otherwise
  assign mac_ina = beat_c ? a_data : 8'd0;
  assign mac_inb = beat_c ? b_data : 8'd0;

  assign res_data = res_data_q;
  assign res_ovf  = res_ovf_q;

  // State register
  always_ff @(posedge clk or negedge aclrn) begin
    if (!aclrn) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = (len != '0) ? CLEAR : RESULT;
      CLEAR:   state_d = RUN;
      RUN:     if (beat_c && (cnt_q == LEN_W'(1))) state_d = DRAIN;
      DRAIN:   state_d = RESULT;
      RESULT:  if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Beat counter, wrap tracking and result capture
  always_ff @(posedge clk or negedge aclrn) begin
    if (!aclrn) begin
      cnt_q      <= '0;
      prev_q     <= 16'd0;
      beat_q     <= 1'b0;
      ovf_q      <= 1'b0;
      res_data_q <= 16'd0;
      res_ovf_q  <= 1'b0;
    end else begin
      prev_q <= mac_out;
      beat_q <= beat_c;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (len != '0) begin
              cnt_q <= len;
              ovf_q <= 1'b0;
            end else begin
              res_data_q <= 16'd0;
              res_ovf_q  <= 1'b0;
            end
          end
        end
        RUN: begin
          if (beat_c) cnt_q <= cnt_q - LEN_W'(1);
          if (wrap_c) ovf_q <= 1'b1;
        end
        DRAIN: begin
          res_data_q <= mac_out;
          res_ovf_q  <= ovf_q | wrap_c;
          ovf_q      <= ovf_q | wrap_c;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_seq.sv
// tb_mac_seq: drives jobs into mac_seq with a behavioural MAC attached and
// checks results against dot products computed directly from the operands.
module tb_mac_seq;

  localparam int unsigned LEN_W = 8;

  logic             clk = 1'b0;
  logic             aclrn = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             busy;
  logic [7:0]       a_data = 8'd0;
  logic [7:0]       b_data = 8'd0;
  logic             op_valid = 1'b0;
  logic             op_ready;
  logic [7:0]       mac_ina;
  logic [7:0]       mac_inb;
  logic             mac_sclrn;
  logic [15:0]      mac_out;
  logic [15:0]      res_data;
  logic             res_ovf;
  logic             res_valid;
  logic             res_ready = 1'b0;

  logic [15:0]      acc = 16'h5a5a;
  int               n_vec = 0;
  int               n_err = 0;
  int               ja [256];
  int               jb [256];

  mac_seq #(.LEN_W(LEN_W)) dut (
    .clk(clk), .aclrn(aclrn), .start(start), .len(len), .busy(busy),
    .a_data(a_data), .b_data(b_data), .op_valid(op_valid), .op_ready(op_ready),
    .mac_ina(mac_ina), .mac_inb(mac_inb), .mac_sclrn(mac_sclrn), .mac_out(mac_out),
    .res_data(res_data), .res_ovf(res_ovf), .res_valid(res_valid), .res_ready(res_ready)
  );

  always #5 clk = ~clk;

  // External MAC: one-cycle accumulate, synchronous clear, not touched by aclrn
  assign mac_out = acc;
  always @(posedge clk) begin
    if (!mac_sclrn) acc <= 16'd0;
    else            acc <= acc + 16'(mac_ina) * 16'(mac_inb);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Run one job from an IDLE cycle. mode 0: valid always, 1: alternating, 2: random.
  task automatic run_job(input int n, input int mode, input int hold, input bit poke);
    int sum = 0;
    int cyc, beats, last_beat, clr_cnt, first_rdy, exp_lat;
    logic [15:0] exp_d;
    logic        exp_o;
    logic [15:0] exp_in;
    for (int i = 0; i < n; i++) sum += ja[i] * jb[i];
    exp_d = 16'(sum);
    exp_o = (sum >= 65536);
    start = 1'b1;
    len = LEN_W'(n);
    op_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1; beats = 0; last_beat = 0; clr_cnt = 0; first_rdy = 0;
    while (!res_valid && cyc < 10 * n + 20) begin
      case (mode)
        0:       op_valid = 1'b1;
        1:       op_valid = (cyc % 2 == 0);
        default: op_valid = ($urandom_range(3) != 0);
      endcase
      a_data = 8'(ja[beats & 255]);
      b_data = 8'(jb[beats & 255]);
      #1;
      if (!mac_sclrn) clr_cnt++;
      if (op_ready && first_rdy == 0) first_rdy = cyc;
      exp_in = (op_ready && op_valid) ? {a_data, b_data} : 16'd0;
      chk("mac_in", 32'({mac_ina, mac_inb}), 32'(exp_in));
      if (op_ready && op_valid) begin
        beats++;
        last_beat = cyc;
      end
      @(posedge clk); #1;
      cyc++;
    end
    op_valid = 1'b0;
    if (n == 0)         exp_lat = 1;
    else if (mode == 0) exp_lat = n + 3;
    else if (mode == 1) exp_lat = 2 * n + 2;
    else                exp_lat = last_beat + 2;
    chk("latency", 32'(cyc), 32'(exp_lat));
    chk("beats", 32'(beats), 32'(n));
    chk("first_ready", 32'(first_rdy), (n == 0) ? 32'd0 : 32'd2);
    chk("clear_cycles", 32'(clr_cnt), (n == 0) ? 32'd0 : 32'd1);
    chk("res_data", 32'(res_data), 32'(exp_d));
    chk("res_ovf", 32'(res_ovf), 32'(exp_o));
    for (int h = 0; h < hold; h++) begin
      if (poke && h == 1) begin
        start = 1'b1;
        len = LEN_W'(5);
      end
      @(posedge clk); #1;
      start = 1'b0;
      chk("hold_valid", 32'(res_valid), 32'd1);
      chk("hold_data", 32'(res_data), 32'(exp_d));
      chk("hold_ovf", 32'(res_ovf), 32'(exp_o));
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("post_valid", 32'(res_valid), 32'd0);
    chk("post_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #3;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(op_ready), 32'd0);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_data", 32'(res_data), 32'd0);
    chk("rst_ovf", 32'(res_ovf), 32'd0);
    chk("rst_sclrn", 32'(mac_sclrn), 32'd1);
    chk("rst_ina", 32'({mac_ina, mac_inb}), 32'd0);
    #4 aclrn = 1'b1;
    @(posedge clk); #1;

    // Basic job, then the same job with alternating bubbles
    ja[0] = 1; ja[1] = 2; ja[2] = 3;
    jb[0] = 4; jb[1] = 5; jb[2] = 6;
    run_job(3, 0, 0, 1'b0);
    run_job(3, 1, 0, 1'b0);

    // Wrap case followed by a job that must start with a clean flag
    ja[0] = 255; ja[1] = 255; jb[0] = 255; jb[1] = 255;
    run_job(2, 0, 0, 1'b0);
    ja[0] = 2; jb[0] = 3;
    run_job(1, 0, 0, 1'b0);

    // Empty job
    run_job(0, 0, 0, 1'b0);

    // Stalled consumer with start poked during RESULT, then back-to-back job
    ja[0] = 2; jb[0] = 3;
    run_job(1, 0, 5, 1'b1);
    ja[0] = 7; jb[0] = 9;
    run_job(1, 0, 0, 1'b0);

    // Reset mid-RUN of a len=4 job
    for (int i = 0; i < 4; i++) begin ja[i] = 10; jb[i] = 11; end
    start = 1'b1; len = LEN_W'(4);
    @(posedge clk); #1;
    start = 1'b0;
    op_valid = 1'b1; a_data = 8'd10; b_data = 8'd11;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_busy", 32'(busy), 32'd1);
    #2 aclrn = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_ready", 32'(op_ready), 32'd0);
    chk("arst_valid", 32'(res_valid), 32'd0);
    chk("arst_ina", 32'({mac_ina, mac_inb}), 32'd0);
    op_valid = 1'b0;
    #1 aclrn = 1'b1;
    @(posedge clk); #1;
    ja[0] = 7; jb[0] = 9;
    run_job(1, 0, 0, 1'b0);

    // Randomized jobs, biased toward large operands to exercise wrap
    for (int j = 0; j < 25; j++) begin
      int n;
      n = $urandom_range(12);
      for (int i = 0; i < n; i++) begin
        ja[i] = ($urandom_range(1) != 0) ? $urandom_range(255) : $urandom_range(255, 200);
        jb[i] = ($urandom_range(1) != 0) ? $urandom_range(255) : $urandom_range(255, 200);
      end
      run_job(n, $urandom_range(2), $urandom_range(3), ($urandom_range(1) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mac_seq.md
# mac_seq

Job sequencer for one `mac` multiply-accumulate instance: accepts a dot-product job of `len` operand pairs, streams them into the MAC through a valid/ready handshake, and clears the accumulator before each job. It waits out the MAC's one-cycle accumulate latency, then presents the 16-bit result with a sticky wrap-around flag on a valid/ready result port. It sits between the operand source (buffer/DMA) and the result consumer, and owns the `mac` instance's `ina`, `inb` and `sclrn` inputs exclusively.

## Interface
- `LEN_W`, default 8: width of job length; max job = 2^LEN_W − 1 pairs.
- `clk` in 1: single clock; all registers rise-edge.
- `aclrn` in 1: asynchronous active-low reset.
- `start` in 1: job request; sampled only in IDLE.
- `len` in LEN_W: pair count; latched with `start`.
- `busy` out 1: high in every state except IDLE.
- `a_data`, `b_data` in 8 each: unsigned operand pair.
- `op_valid` in 1 / `op_ready` out 1: operand handshake; a beat is transferred when both are high on a rising edge.
- `mac_ina`, `mac_inb` out 8 each: to MAC multiplier inputs.
- `mac_sclrn` out 1: to MAC synchronous clear, active low.
- `mac_out` in 16: MAC accumulator output.
- `res_data` out 16: result, registered.
- `res_ovf` out 1: result wrapped modulo 2^16 at least once.
- `res_valid` out 1 / `res_ready` in 1: result handshake.

## Operation
- States: IDLE, CLEAR, RUN, DRAIN, RESULT.
- IDLE:
  - `op_ready`=0, `mac_sclrn`=1.
  - `start`=1 and `len`≠0 → latch `cnt`=`len`, clear `ovf`, go to CLEAR.
  - `start`=1 and `len`=0 → `res_data`=0, `res_ovf`=0, go to RESULT.
- CLEAR: `mac_sclrn`=0 for exactly one cycle, then RUN.
- RUN:
  - `op_ready`=1.
  - Each beat decrements `cnt`.
  - Beat with `cnt`=1 → DRAIN; `op_ready` is 0 from the next cycle.
- DRAIN: one cycle. At the exit edge: `res_data`←`mac_out`, final `ovf` update, then RESULT.
- RESULT:
  - `res_valid`=1; `res_data` and `res_ovf` held stable.
  - `res_ready`=1 → IDLE.
- `mac_ina`/`mac_inb` are combinational: `a_data`/`b_data` when a beat fires, else 0.
  - The MAC therefore adds 0 on idle, bubble, CLEAR and DRAIN cycles, and the accumulator stays stable between beats.
- Overflow detection:
  - Register `mac_out` every cycle as `prev`, and register a beat-fired flag `beat_d`.
  - In RUN or DRAIN, if `beat_d`=1 and `mac_out` < `prev`, set `ovf`.
  - This is exact because a product is ≤ 65025 < 2^16, so each beat wraps at most once.
  - `beat_d` gates out the CLEAR→RUN drop to 0.
- `start` is ignored while `busy`=1; no queueing.
- Operand arithmetic: unsigned 8×8→16; the accumulator wraps modulo 2^16 (MAC behaviour). The controller never saturates.

## Timing
- Reset (`aclrn`=0, asynchronous):
  - State → IDLE.
  - `busy`, `op_ready`, `res_valid`, `res_ovf`, `cnt`, `prev`, `beat_d` all 0; `res_data` = 0.
  - `mac_sclrn`=1; `mac_ina`/`mac_inb`=0.
- Reset mid-job: the job is abandoned and `mac_out` is left stale. This is harmless because every job passes through CLEAR.
- Latency, with `start` sampled at cycle 0 and `op_valid` held high:
  - CLEAR at cycle 1.
  - RUN at cycles 2..len+1.
  - DRAIN at cycle len+2.
  - `res_valid`=1 from cycle len+3.
- Bubbles (`op_valid`=0) extend RUN one cycle each; the result is unchanged.
- `len`=0: `res_valid`=1 at cycle 1.
- Throughput: one beat per cycle in RUN. Job-to-job minimum gap is 1 IDLE cycle after the result handshake.
- `op_ready` is a registered state decode; it does not depend combinationally on `op_valid`.

## Test plan
- `len`=3, a={1,2,3}, b={4,5,6}, `op_valid` constant high → `res_data`=32, `res_ovf`=0, `res_valid` first high 6 cycles after the `start` cycle.
- Same job with `op_valid` low on alternate cycles → `res_data`=32, `res_valid` 2 cycles later than the constant-valid case, exactly 3 beats consumed.
- `len`=2, a=b=255 both beats → `res_data`=64514 (130050 mod 65536), `res_ovf`=1. Next job `len`=1, 2×3 → `res_data`=6, `res_ovf`=0.
- `len`=0 → `res_valid`=1 at cycle 1, `res_data`=0, `op_ready` never high, `mac_sclrn` never low.
- `res_ready` held low 5 cycles with `start` pulsed during RESULT → `res_data`/`res_valid` stable and `start` ignored. After the handshake, a back-to-back job `len`=1, 7×9 → 63.
- `aclrn` pulsed low mid-RUN of a `len`=4 job → `busy`, `op_ready`, `res_valid` go 0 immediately. Following job `len`=1, 7×9 → `res_data`=63, proving CLEAR discarded the stale accumulator.
